seg7_scan_ctrl: RTL and testbench

Time-multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS common-anode digits. Holds a per-frame display register loaded through a tear-free shadow/commit handshake. Drives the decoder's nibble input and the active-low anode enables. Inserts dead-time gaps between digits to suppress ghosting. Sits between the measurement/result logic and the decoder; the decoder's own fixed anode output is left unused.

---
 rtl/seg7_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller; optional SEG7_LZB_EN adds leading-zero blanking
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic                    load_ack,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              data_out,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    frame_tick
);

    // Prescaler must hold the longer of the SHOW and GAP durations; never narrower than 1 bit.
    localparam int PMAX_RD = (REFRESH_DIV > 2) ? REFRESH_DIV : 2;
    localparam int PMAX    = (DEAD_CYCLES > PMAX_RD) ? DEAD_CYCLES : PMAX_RD;
    localparam int PW      = $clog2(PMAX);
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] SHOW_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]    BLANK     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_d;
    logic [IW-1:0]           idx_inc;
    logic [PW-1:0]           presc;
    logic [PW-1:0]           presc_d;
    logic                    show_entry;
    logic                    frame_start;

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] disp_d;
    logic                    pending;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   lz_blank;

    logic [NUM_DIGITS-1:0]   an_d;
    logic [3:0]              data_d;

`ifdef SEG7_LZB_EN
    // Blank zero nibbles from the most significant digit down until the first nonzero one; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (run && (v[4*i +: 4] == 4'h0)) begin
                m[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
        return m;
    endfunction

    assign lz_blank = lzb_mask(disp_d);
`else
    assign lz_blank = '0;
`endif

    assign idx_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // Scan sequencer: IDLE until enabled, then SHOW each digit for REFRESH_DIV cycles with optional GAP between.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        presc_d     = presc;
        show_entry  = 1'b0;
        frame_start = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            presc_d = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_d     = ST_SHOW;
                    idx_d       = '0;
                    presc_d     = '0;
                    show_entry  = 1'b1;
                    frame_start = 1'b1;
                end
                ST_SHOW: begin
                    if (presc == SHOW_LAST) begin
                        presc_d = '0;
                        if (DEAD_CYCLES == 0) begin
                            state_d     = ST_SHOW;
                            idx_d       = idx_inc;
                            show_entry  = 1'b1;
                            frame_start = (idx_inc == '0);
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        presc_d = presc + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (presc == GAP_LAST) begin
                        state_d     = ST_SHOW;
                        presc_d     = '0;
                        idx_d       = idx_inc;
                        show_entry  = 1'b1;
                        frame_start = (idx_inc == '0);
                    end else begin
                        presc_d = presc + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    presc_d = '0;
                end
            endcase
        end
    end

    // Commit only at a frame boundary so a frame never mixes old and new digits; IDLE has no frame to protect.
    assign commit = pending && ((state == ST_IDLE) || frame_start);
    assign disp_d = commit ? shadow : display;

    // Next output values; a SHOW digit's nibble and blanking are fixed at entry and held for its whole slot.
    always_comb begin
        an_d   = '1;
        data_d = BLANK;
        if (state_d == ST_SHOW) begin
            an_d = ~(NUM_DIGITS'(1) << idx_d);
            if (show_entry) begin
                data_d = (blank_mask[idx_d] || lz_blank[idx_d]) ? BLANK : disp_d[{idx_d, 2'b00} +: 4];
            end else begin
                data_d = data_out;
            end
        end
    end

    // FSM state, digit index and prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            presc <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            presc <= presc_d;
        end
    end

    // Shadow capture and commit; a load coinciding with a commit stays pending for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            display <= disp_d;
            if (load) begin
                shadow  <= value_in;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered outputs, updated on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AN         <= '1;
            data_out   <= BLANK;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            AN         <= an_d;
            data_out   <= data_d;
            load_ack   <= commit;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int DC    = 1;
    localparam int SLOT  = RD + DC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        load_ack;
    logic        frame_tick;
    logic [3:0]  data_out;
    logic [3:0]  AN;

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .value_in  (value_in),
        .load      (load),
        .load_ack  (load_ack),
        .blank_mask(blank_mask),
        .data_out  (data_out),
        .AN        (AN),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [3:0] an;
        logic [3:0] data;
        logic       ack;
        logic       tick;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } hc_t;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  mask;
        logic [15:0] expd;
    } vec_t;

    exp_t sb[$];
    hc_t  hq[$];
    exp_t me;
    hc_t  mh;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gen = 0;
    int ack_cnt = 0;
    logic [3:0] cap [ND];
    int         cap_gen [ND];

    // Reference model state: position within a 20-cycle frame rather than FSM/prescaler.
    bit          m_run = 0;
    int          m_pos = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_pend = 0;
    logic [3:0]  m_data = 4'hF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, req);
        end
    endtask

    // Scoreboard consumer and digit capture, sampled on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            me = sb.pop_front();
            check("an", 32'(AN), 32'(me.an));
            check("data_out", 32'(data_out), 32'(me.data));
            check("load_ack", 32'(load_ack), 32'(me.ack));
            check("frame_tick", 32'(frame_tick), 32'(me.tick));
        end
        while (hq.size() > 0) begin
            mh = hq.pop_front();
            check(mh.name, mh.act, mh.req);
        end
        for (int i = 0; i < ND; i++) begin
            if (AN == ~(4'b0001 << i)) begin
                cap[i]     = data_out;
                cap_gen[i] = gen;
            end
        end
        if (load_ack === 1'b1) ack_cnt++;
    end

    task automatic hcheck(input string nm, input logic [31:0] act, input logic [31:0] req);
        hc_t h;
        h.name = nm;
        h.act  = act;
        h.req  = req;
        hq.push_back(h);
    endtask

`ifdef SEG7_LZB_EN
    function automatic logic [3:0] lz(input logic [15:0] v);
        logic [3:0] r;
        bit         run;
        r   = 4'h0;
        run = 1;
        for (int i = ND - 1; i >= 1; i--) begin
            if (run && v[4*i +: 4] == 4'h0) r[i] = 1'b1;
            else run = 0;
        end
        return r;
    endfunction
`endif

    // Apply one cycle of inputs and push the outputs expected after the next rising edge.
    task automatic drive(input bit r, input bit e, input bit l, input logic [15:0] v, input logic [3:0] m);
        exp_t       x;
        bit         cm;
        int         dig;
        logic [3:0] lzm;
        @(negedge clk);
        #1;
        rst_n = r;
        en = e;
        load = l;
        value_in = v;
        blank_mask = m;
        x.due  = cyc + 1;
        x.an   = 4'hF;
        x.data = 4'hF;
        x.ack  = 1'b0;
        x.tick = 1'b0;
        if (!r) begin
            m_run = 0; m_pos = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 0; m_data = 4'hF;
        end else begin
            cm = m_pend && (!m_run || (e && m_pos == FRAME - 1));
            x.ack = cm;
            if (cm) m_disp = m_shadow;
            if (l) begin
                m_shadow = v;
                m_pend = 1;
            end else if (cm) begin
                m_pend = 0;
            end
            if (!e) begin
                m_run = 0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            if (m_run) begin
                dig = m_pos / SLOT;
                x.tick = (m_pos == 0);
                if (m_pos % SLOT < RD) begin
                    x.an = ~(4'b0001 << dig);
`ifdef SEG7_LZB_EN
                    lzm = lz(m_disp);
`else
                    lzm = 4'h0;
`endif
                    if (m_pos % SLOT == 0) m_data = (m[dig] || lzm[dig]) ? 4'hF : m_disp[4*dig +: 4];
                    x.data = m_data;
                end
            end
        end
        sb.push_back(x);
    endtask

    task automatic run_to(input int pos, input logic [3:0] m);
        for (int k = 0; k < 2 * FRAME && m_pos != pos; k++) drive(1'b1, 1'b1, 1'b0, 16'h0, m);
    endtask

    task automatic frame_word(output logic [15:0] w);
        for (int i = 0; i < ND; i++) w[4*i +: 4] = (cap_gen[i] == gen) ? cap[i] : 4'hx;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t        tbl [6];
    logic [15:0] w;
    int          a0;

    initial begin
        tbl[0] = '{val: 16'h1234, mask: 4'b0000, expd: 16'h1234};
        tbl[1] = '{val: 16'h1234, mask: 4'b0100, expd: 16'h1F34};
        tbl[3] = '{val: 16'hABCD, mask: 4'b1001, expd: 16'hFBCF};
`ifdef SEG7_LZB_EN
        tbl[2] = '{val: 16'h0040, mask: 4'b0000, expd: 16'hFF40};
        tbl[4] = '{val: 16'h0000, mask: 4'b0000, expd: 16'hFFF0};
        tbl[5] = '{val: 16'h0905, mask: 4'b0010, expd: 16'hF9F5};
`else
        tbl[2] = '{val: 16'h0040, mask: 4'b0000, expd: 16'h0040};
        tbl[4] = '{val: 16'h0000, mask: 4'b0000, expd: 16'h0000};
        tbl[5] = '{val: 16'h0905, mask: 4'b0010, expd: 16'h09F5};
`endif
        for (int i = 0; i < ND; i++) cap_gen[i] = -1;

        drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);

        // Table: load in IDLE, enable, scan one full frame and compare every digit.
        for (int t = 0; t < 6; t++) begin
            drive(1'b1, 1'b0, 1'b1, tbl[t].val, tbl[t].mask);
            drive(1'b1, 1'b0, 1'b0, 16'h0, tbl[t].mask);
            drive(1'b1, 1'b1, 1'b0, 16'h0, tbl[t].mask);
            gen++;
            run_to(FRAME - 1, tbl[t].mask);
            frame_word(w);
            hcheck($sformatf("table[%0d]", t), 32'(w), 32'(tbl[t].expd));
        end

        // Mid-frame double load: last value wins, one ack at the wrap; a load at the commit edge stays pending.
        drive(1'b1, 1'b0, 1'b1, 16'h1234, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        run_to(7, 4'h0);
        a0 = ack_cnt;
        drive(1'b1, 1'b1, 1'b1, 16'hAAAA, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 16'h5678, 4'h0);
        run_to(FRAME - 1, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 16'h9999, 4'h0);
        gen++;
        run_to(FRAME - 1, 4'h0);
        frame_word(w);
        hcheck("wrap_value", 32'(w), 32'h5678);
        hcheck("single_ack", 32'(ack_cnt - a0), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        gen++;
        run_to(FRAME - 1, 4'h0);
        frame_word(w);
        hcheck("late_load_value", 32'(w), 32'h9999);

        // Drop enable during digit 2, then restart at digit 0 with a frame tick.
        run_to(11, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        @(posedge clk);
        #1;
        hcheck("reenable_an", 32'(AN), 32'h0000000E);
        hcheck("reenable_tick", 32'(frame_tick), 32'd1);

        // Asynchronous reset in the middle of digit 2: outputs go idle before the next edge.
        run_to(11, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        #1;
        hcheck("pre_reset_an", 32'(AN), 32'h0000000B);
        rst_n = 1'b0;
        #1;
        hcheck("async_rst_an", 32'(AN), 32'h0000000F);
        hcheck("async_rst_data", 32'(data_out), 32'h0000000F);
        hcheck("async_rst_ack", 32'(load_ack), 32'd0);
        hcheck("async_rst_tick", 32'(frame_tick), 32'd0);
        sb.delete();
        drive(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        run_to(FRAME - 1, 4'h0);

        repeat (2) @(negedge clk);
        #1;
        hcheck("scoreboard_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
